// File: rtl/skin_width_pipe.sv
// skin_width_pipe: 3-stage piecewise-linear chroma width generator.
// Optional clamp to [0, 2^(OUT_W-1)-1] when SKIN_WIDTH_SAT_EN is defined.
module skin_width_pipe #(
    parameter int Y_W   = 8,
    parameter int OUT_W = 32,
    parameter int FRAC_W = 16,
    parameter int TAG_W = 4,
    parameter int KL    = 125,
    parameter int KH    = 188,
    parameter logic [OUT_W-1:0] CB_LO_BASE  = 32'h0004DED0,
    parameter logic [OUT_W-1:0] CB_LO_SLOPE = 32'h00000E13,
    parameter logic [OUT_W-1:0] CB_HI_BASE  = 32'h000BBE14,
    parameter logic [OUT_W-1:0] CB_HI_SLOPE = 32'h00002CE5,
    parameter logic [OUT_W-1:0] CR_LO_BASE  = 32'h00049F02,
    parameter logic [OUT_W-1:0] CR_LO_SLOPE = 32'h00000C3A,
    parameter logic [OUT_W-1:0] CR_HI_BASE  = 32'h000A2000,
    parameter logic [OUT_W-1:0] CR_HI_SLOPE = 32'h00002800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    input  logic             in_sel_cr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_width,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_seg
);

    localparam int PW = OUT_W + Y_W;
    localparam int RW = OUT_W + Y_W + 1;
    localparam logic [1:0] SEG_L = 2'b01;
    localparam logic [1:0] SEG_M = 2'b00;
    localparam logic [1:0] SEG_H = 2'b10;
    localparam logic [Y_W-1:0] KH_Y = Y_W'(KH);

    logic adv;
    logic accept;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && in_ready;

    // stage 1 registers
    logic             v1;
    logic [1:0]       seg1;
    logic [Y_W-1:0]   d1;
    logic [OUT_W-1:0] base1;
    logic [OUT_W-1:0] slope1;
    logic [TAG_W-1:0] tag1;

    // stage 2 registers
    logic             v2;
    logic [1:0]       seg2;
    logic [OUT_W-1:0] base2;
    logic [PW-1:0]    p2;
    logic [TAG_W-1:0] tag2;

    // stage 1 next-state
    logic [1:0]       seg_n;
    logic [Y_W-1:0]   d_n;
    logic [OUT_W-1:0] base_n;
    logic [OUT_W-1:0] slope_n;

    // stage 2 / 3 datapath
    logic [PW-1:0]    p_n;
    logic [RW-1:0]    base_x;
    logic [RW-1:0]    p_x;
    logic [RW-1:0]    res_x;
    logic [OUT_W-1:0] res_n;

    // segment classification, offset and coefficient select
    always_comb begin
        seg_n = SEG_M;
        d_n   = '0;
        if (int'(in_y) <= KL) begin
            seg_n = SEG_L;
            d_n   = in_y;
        end else if (int'(in_y) >= KH) begin
            seg_n = SEG_H;
            d_n   = in_y - KH_Y;
        end
        if (in_sel_cr) begin
            base_n  = (seg_n == SEG_H) ? CR_HI_BASE : CR_LO_BASE;
            slope_n = (seg_n == SEG_H) ? CR_HI_SLOPE : CR_LO_SLOPE;
        end else begin
            base_n  = (seg_n == SEG_H) ? CB_HI_BASE : CB_LO_BASE;
            slope_n = (seg_n == SEG_H) ? CB_HI_SLOPE : CB_LO_SLOPE;
        end
    end

    // full-precision unsigned product
    assign p_n = PW'(slope1) * PW'(d1);

    // wide signed add/sub, then wrap or clamp to output width
    always_comb begin
        base_x = {{(Y_W + 1){base2[OUT_W-1]}}, base2};
        p_x    = {1'b0, p2};
        res_x  = '0;
        unique case (1'b1)
            seg2 == SEG_L: res_x = base_x + p_x;
            seg2 == SEG_H: res_x = base_x - p_x;
            default:       res_x = '0;
        endcase
`ifdef SKIN_WIDTH_SAT_EN
        if (res_x[RW-1]) begin
            res_n = '0;
        end else if (|res_x[RW-2:OUT_W-1]) begin
            res_n = {1'b0, {(OUT_W - 1){1'b1}}};
        end else begin
            res_n = res_x[OUT_W-1:0];
        end
`else
        res_n = res_x[OUT_W-1:0];
`endif
    end

    // stage 1: capture classified sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            seg1   <= '0;
            d1     <= '0;
            base1  <= '0;
            slope1 <= '0;
            tag1   <= '0;
        end else if (adv) begin
            v1     <= accept;
            seg1   <= seg_n;
            d1     <= d_n;
            base1  <= base_n;
            slope1 <= slope_n;
            tag1   <= in_tag;
        end
    end

    // stage 2: register product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            seg2  <= '0;
            base2 <= '0;
            p2    <= '0;
            tag2  <= '0;
        end else if (adv) begin
            v2    <= v1;
            seg2  <= seg1;
            base2 <= base1;
            p2    <= p_n;
            tag2  <= tag1;
        end
    end

    // stage 3: registered outputs, held while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_width <= '0;
            out_tag   <= '0;
            out_seg   <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                out_width <= res_n;
                out_tag   <= tag2;
                out_seg   <= seg2;
            end
        end
    end

endmodule
